song_sequencer: RTL and testbench

//  Autoplay melody source for the piano top level. Steps through a fixed on-chip note table
//  (first phrase of Ode to Joy) at a programmable tempo and emits a 4-bit note code plus a
//  one-hot LED pattern per note. The top level muxes these with the switch path in autoplay

---
 rtl/song_sequencer.sv | 141 ++++++++++++++
 tb/tb_song_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Autoplay melody source: steps through an on-chip note table at a programmable tempo.
// Define SONG_LOOP_EN to restart at entry 0 after each done pulse instead of returning to idle.
module song_sequencer #(
   parameter int TICK_CYCLES = 12_500_000,
   parameter int GAP_CYCLES  = 1_250_000,
   parameter int SONG_LEN    = 15
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic                        start,
   input  logic                        stop,
   output logic [3:0]                  note,
   output logic [7:0]                  Led,
   output logic                        playing,
   output logic                        done,
   output logic [$clog2(SONG_LEN)-1:0] index
);

   localparam int IW = $clog2(SONG_LEN);
   localparam int CW = $clog2(7 * TICK_CYCLES);
   localparam logic [IW-1:0] LAST_IDX = IW'(SONG_LEN - 1);
   localparam logic [31:0]   GAP_LAST = 32'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   index_q, index_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [3:0]      note_q, note_d;
   logic [2:0]      dur_q, dur_d;
   logic [6:0]      nxt_entry;
   logic [31:0]     play_last;

   // Table entry = {note, duration in ticks}; first phrase of Ode to Joy.
   function automatic logic [6:0] song_entry(input logic [IW-1:0] idx);
      case (int'(idx))
         0:       song_entry = {4'd3, 3'd2};
         1:       song_entry = {4'd3, 3'd2};
         2:       song_entry = {4'd4, 3'd2};
         3:       song_entry = {4'd5, 3'd2};
         4:       song_entry = {4'd5, 3'd2};
         5:       song_entry = {4'd4, 3'd2};
         6:       song_entry = {4'd3, 3'd2};
         7:       song_entry = {4'd2, 3'd2};
         8:       song_entry = {4'd1, 3'd2};
         9:       song_entry = {4'd1, 3'd2};
         10:      song_entry = {4'd2, 3'd2};
         11:      song_entry = {4'd3, 3'd2};
         12:      song_entry = {4'd3, 3'd3};
         13:      song_entry = {4'd2, 3'd1};
         14:      song_entry = {4'd2, 3'd4};
         default: song_entry = {4'd0, 3'd1};
      endcase
   endfunction

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         index_q <= '0;
         cnt_q   <= '0;
         note_q  <= 4'd0;
         dur_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         cnt_q   <= cnt_d;
         note_q  <= note_d;
         dur_q   <= dur_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      cnt_d     = cnt_q + 1'b1;
      play_last = 32'(dur_q) * 32'(TICK_CYCLES) - 32'(GAP_CYCLES) - 32'd1;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d = S_PLAY;
               index_d = '0;
            end
         end
         S_PLAY: begin
            if (32'(cnt_q) == play_last) begin
               state_d = S_GAP;
               cnt_d   = '0;
            end
         end
         S_GAP: begin
            if (32'(cnt_q) == GAP_LAST) begin
               cnt_d = '0;
               if (index_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_PLAY;
                  index_d = index_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            cnt_d   = '0;
            index_d = '0;
`ifdef SONG_LOOP_EN
            state_d = S_PLAY;
`else
            state_d = S_IDLE;
`endif
         end
         default: begin
            state_d = S_IDLE;
            index_d = '0;
            cnt_d   = '0;
         end
      endcase

      // Stop overrides everything, including a simultaneous start.
      if (stop) begin
         state_d = S_IDLE;
         index_d = '0;
         cnt_d   = '0;
      end

      nxt_entry = song_entry(index_d);
      note_d    = (state_d == S_PLAY) ? nxt_entry[6:3] : 4'd0;
      dur_d     = nxt_entry[2:0];
   end

   always_comb begin
      Led = 8'h00;
      if (note_q >= 4'd1 && note_q <= 4'd8) Led = 8'h80 >> (note_q - 4'd1);
   end

   assign note    = note_q;
   assign index   = index_q;
   assign playing = (state_q == S_PLAY) || (state_q == S_GAP);
   assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICK_CYCLES=10, GAP_CYCLES=2; honours SONG_LOOP_EN.
module tb_song_sequencer;

   localparam int TICK = 10;
   localparam int GAP  = 2;
   localparam int LEN  = 15;
   localparam int W    = 10;  // {done, playing, index[3:0], note[3:0]}

   logic       clk, rst, start, stop;
   logic [3:0] note;
   logic [7:0] led;
   logic       playing, done;
   logic [3:0] index;

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];

   int song_note[15] = '{3, 3, 4, 5, 5, 4, 3, 2, 1, 1, 2, 3, 3, 2, 2};
   int song_dur[15]  = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 1, 4};

   song_sequencer #(.TICK_CYCLES(TICK), .GAP_CYCLES(GAP), .SONG_LEN(LEN)) dut (
      .CLK(clk), .RESET(rst), .start(start), .stop(stop),
      .note(note), .Led(led), .playing(playing), .done(done), .index(index)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] led_of(input logic [3:0] n);
      case (n)
         4'd1: led_of = 8'h80;
         4'd2: led_of = 8'h40;
         4'd3: led_of = 8'h20;
         4'd4: led_of = 8'h10;
         4'd5: led_of = 8'h08;
         4'd6: led_of = 8'h04;
         4'd7: led_of = 8'h02;
         4'd8: led_of = 8'h01;
         default: led_of = 8'h00;
      endcase
   endfunction

   // Expected outputs at cycle c counted from the first sounding cycle (c=0).
   function automatic logic [W-1:0] exp_vec(input int c);
      int base;
      base = 0;
`ifdef SONG_LOOP_EN
      c = c % 321;
`endif
      if (c == 320) return {1'b1, 1'b0, 4'd14, 4'd0};
      if (c > 320) return '0;
      for (int i = 0; i < LEN; i++) begin
         int len;
         len = song_dur[i] * TICK;
         if (c < base + len)
            return {1'b0, 1'b1, 4'(i), (c - base < len - GAP) ? 4'(song_note[i]) : 4'd0};
         base += len;
      end
      return '0;
   endfunction

   // driver tasks (called at a negedge, return at a negedge)
   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_note"}, 32'(note), 32'd0);
      chk({tag, "_led"}, 32'(led), 32'd0);
      chk({tag, "_playing"}, 32'(playing), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_index"}, 32'(index), 32'd0);
   endtask

   // Scoreboard over playback cycles c0..c1; a start pulse is injected after cycle start_at.
   task automatic run_song(input string tag, input int c0, input int c1, input int start_at);
      logic [W-1:0] e;
      for (int c = c0; c <= c1; c++) exp_q.push_back(exp_vec(c));
      for (int c = c0; c <= c1; c++) begin
         e = exp_q.pop_front();
         chk($sformatf("%s_note_c%0d", tag, c), 32'(note), 32'(e[3:0]));
         chk($sformatf("%s_led_c%0d", tag, c), 32'(led), 32'(led_of(e[3:0])));
         chk($sformatf("%s_playing_c%0d", tag, c), 32'(playing), 32'(e[8]));
         chk($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(e[9]));
         if (!e[9]) chk($sformatf("%s_index_c%0d", tag, c), 32'(index), 32'(e[7:4]));
         start = (c == start_at);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      int busy;
      rst   = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("in_reset");
      rst = 1'b0;

      // 1: idle after reset
      busy = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (note != 0 || led != 0 || playing || done) busy++;
      end
      chk("idle_after_reset", 32'(busy), 32'd0);

      // 2+3: full song, with a second start at cycle 50 that must be ignored
      pulse_start();
      chk("first_note", 32'(note), 32'd3);
      chk("first_led", 32'(led), 32'h20);
      run_song("song", 0, 325, 50);
      pulse_stop();
      check_idle("after_song");

      // 4: stop mid-playback, no done pulse, then restart from entry 0
      pulse_start();
      run_song("pre_stop", 0, 100, -1);
      pulse_stop();
      check_idle("after_stop");
      busy = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done || playing || note != 0) busy++;
      end
      chk("quiet_after_stop", 32'(busy), 32'd0);
      pulse_start();
      run_song("restart", 0, 25, -1);
      pulse_stop();

      // 5: start and stop together while idle
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      check_idle("start_stop_same");
      repeat (20) @(negedge clk);
      check_idle("start_stop_later");

      // 6: asynchronous reset between edges mid-note
      pulse_start();
      run_song("pre_reset", 0, 30, -1);
      #2 rst = 1'b1;
      #1 check_idle("async_reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      busy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (playing || note != 0 || done) busy++;
      end
      chk("idle_after_async_reset", 32'(busy), 32'd0);
      pulse_start();
      run_song("post_reset", 0, 22, -1);
      pulse_stop();
      check_idle("final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
